// File: rtl/native_split_tmo.sv
// ---------------------------------------------------------------------------
// native_split_tmo
//
// Registered native-bus splitter: one CPU-side master is routed to one of
// N_SLAVES slaves, picked by the address field m_addr[P_SLAVES -: SEL_W].
// Each request is captured into a register stage, so the master-to-slave
// path is flop-to-flop. Unmapped slave indices get an immediate error
// completion. A hung slave is cut off after TIMEOUT cycles with an error
// completion. Error completions are tallied in a saturating 8-bit counter.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   m_valid         master request, held until m_ready
//   m_addr          request address
//   m_wdata         write data
//   m_wstrb         write strobes (all zero = read)
//   m_rdata         response data, valid with m_ready
//   m_ready         one-cycle completion pulse
//   m_err           error qualifier for m_ready
//   s_valid         one-hot request valid, one bit per slave
//   s_addr          registered address, broadcast to all slaves
//   s_wdata         registered write data, broadcast
//   s_wstrb         registered write strobes, broadcast
//   s_rdata         slave read data, slave i in [i*DATA_W +: DATA_W]
//   s_ready         slave completion, one bit per slave
//   err_cnt         number of error completions, saturates at 255
// ---------------------------------------------------------------------------
module native_split_tmo #(
    parameter int N_SLAVES = 2,
    parameter int P_SLAVES = 31,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [N_SLAVES-1:0]          s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic [7:0]                   err_cnt
);

    localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 0;
    localparam int SEL_WR = (SEL_W > 0) ? SEL_W : 1;
    localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [SEL_WR-1:0]   sel;
    logic [N_SLAVES-1:0] sel_onehot;
    logic                mapped;
    logic                hit;
    logic                timeout_hit;
    logic [DATA_W-1:0]   lane_data;
    logic [7:0]          err_cnt_next;

    // With a single slave there is no select field; the only index is 0.
    generate
        if (SEL_W == 0) begin : g_single
            assign sel = '0;
        end else begin : g_field
            assign sel = m_addr[P_SLAVES -: SEL_W];
        end
    endgenerate

    // Decode the select field into the one-hot request vector. Indices at or
    // beyond N_SLAVES (non power-of-two slave counts) decode to all zeros
    // and are reported as unmapped.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            sel_onehot[i] = (int'(sel) == i);
        end
    end

    assign mapped = (int'(sel) < N_SLAVES);

    // The registered s_valid doubles as the captured select: only the
    // selected slave's ready counts, and only its data lane is passed on.
    assign hit = |(s_ready & s_valid);

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_valid[i]) begin
                lane_data = lane_data | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign err_cnt_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Transaction sequencer. Every output is a register; the completion
    // (m_ready/m_err/m_rdata and the error count) is loaded on the way into
    // RESP so the master sees it in the cycle after the slave's ready.
    // A ready from the slave takes priority over a simultaneous timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            s_valid <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            err_cnt <= 8'd0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        cnt     <= '0;
                        if (mapped) begin
                            s_valid <= sel_onehot;
                            state   <= ST_FWD;
                        end else begin
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_FWD: begin
                    if (hit) begin
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= lane_data;
                        state   <= ST_RESP;
                    end else if (timeout_hit) begin
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= ERR_DATA;
                        err_cnt <= err_cnt_next;
                        state   <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    m_ready <= 1'b1;
                    m_err   <= 1'b1;
                    m_rdata <= ERR_DATA;
                    err_cnt <= err_cnt_next;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    m_err <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/native_split_tmo.md
# native_split_tmo

Registered, parametrised native-bus splitter that routes one CPU-side master to `N_SLAVES` slaves. The slave is selected by a bit field of the address. It is the successor of the combinational `split` used on the instruction, data and peripheral buses in `system`. Over `split` it adds:
- a request register stage, so the path from master to slave is flop-to-flop;
- an error response for unmapped slave indices;
- a per-transaction timeout that terminates a hung slave access;
- a saturating error counter.

## Interface
Parameters:
- `N_SLAVES`, 2: number of slave ports, 1..16.
- `P_SLAVES`, 31: MSB position of the slave-select field in `m_addr`.
- `SEL_W`, derived as `clog2(N_SLAVES)` (0 when `N_SLAVES`=1): width of the select field, `m_addr[P_SLAVES -: SEL_W]`.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits.
- `TIMEOUT`, 1023: cycles to wait for `s_ready` before an error completion; 0 disables the timeout.
- `ERR_DATA`, 32'hDEADBEEF: `m_rdata` value on an error completion.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `m_valid` in 1: master request. Held high until `m_ready`.
- `m_addr` in `ADDR_W`: request address.
- `m_wdata` in `DATA_W`: write data.
- `m_wstrb` in `DATA_W/8`: write strobes; all zero means read.
- `m_rdata` out `DATA_W`: response data, valid while `m_ready`=1.
- `m_ready` out 1: one-cycle completion pulse.
- `m_err` out 1: qualifies `m_ready`; 1 means unmapped slave or timeout.
- `s_valid` out `N_SLAVES`: one-hot request valid per slave.
- `s_addr` out `ADDR_W`: registered address, broadcast to all slaves.
- `s_wdata` out `DATA_W`: registered write data, broadcast.
- `s_wstrb` out `DATA_W/8`: registered strobes, broadcast.
- `s_rdata` in `N_SLAVES*DATA_W`: slave read data; slave i occupies `[i*DATA_W +: DATA_W]`.
- `s_ready` in `N_SLAVES`: slave completion, one bit per slave.
- `err_cnt` out 8: number of error completions, saturating at 255.

## Operation
State machine states: IDLE, FWD, ERR, RESP.
- **IDLE**
  - If `m_valid`=1: capture `sel`, `m_addr`, `m_wdata` and `m_wstrb` into registers and clear the timeout counter.
  - If `sel` < `N_SLAVES`, go to FWD; otherwise go to ERR.
  - With `N_SLAVES`=1, `sel` is always 0.
- **FWD**
  - `s_valid[sel]`=1; all other `s_valid` bits are 0. `s_addr`, `s_wdata` and `s_wstrb` are held stable.
  - If `s_ready[sel]`=1: capture `s_rdata` lane `sel`, set `err_q`=0, go to RESP.
  - Else if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1: set `err_q`=1, go to RESP.
  - Otherwise increment the counter.
- **ERR**: set `err_q`=1 and go to RESP.
- **RESP**
  - Drive `m_ready`=1 and `m_err`=`err_q`.
  - `m_rdata` is the captured slave data when `err_q`=0, and `ERR_DATA` when `err_q`=1.
  - If `err_q`=1, increment `err_cnt` unless it is already 255.
  - Go to IDLE.
- `m_valid` is ignored in FWD, ERR and RESP.
- `s_ready` bits from non-selected slaves are ignored in every state.
- Any `s_ready` seen in IDLE is ignored, including a late response from a timed-out slave.
- `rst`: go to IDLE; `s_valid`=0, `m_ready`=0, `m_err`=0, `m_rdata`=0, `err_cnt`=0, `s_addr`/`s_wdata`/`s_wstrb`=0. An in-flight request is dropped with no response.

## Timing
- Every output is driven from a flop; there is no combinational path from input to output.
- Mapped access, request sampled in IDLE at cycle 0:
  - `s_valid` rises in cycle 1.
  - If `s_ready` arrives in cycle k ≥ 1, `s_valid` is 0 from cycle k+1, and `m_ready` pulses in cycle k+1.
  - Minimum master latency is 2 cycles.
- Unmapped access: ERR in cycle 1, `m_ready` with `m_err`=1 in cycle 2.
- Timeout: `s_valid` is high in cycles 1..`TIMEOUT`; `m_ready` with `m_err`=1 in cycle `TIMEOUT`+1.
- `s_ready` in the same cycle as the timeout condition takes priority, giving a normal completion.
- Back-to-back: if the master re-asserts `m_valid` in the cycle after `m_ready`, IDLE samples it. Throughput is one transaction per k+2 cycles.
- After `rst` is released, the first request is accepted in the first cycle `rst`=0.

## Test plan
- `N_SLAVES`=2, read `m_addr`=0x8000_0010 (sel=1), slave 1 returns `s_ready`=1 in cycle 3 with rdata 0x1234_5678 → `s_valid`=2'b10 in cycles 1..3, `m_ready`=1, `m_err`=0, `m_rdata`=0x1234_5678 in cycle 4.
- `N_SLAVES`=3, `P_SLAVES`=31, `m_addr`=0xC000_0000 (sel=3) → all `s_valid`=0, `m_ready`=1, `m_err`=1, `m_rdata`=0xDEADBEEF in cycle 2, `err_cnt`=1.
- `TIMEOUT`=8, slave never responds → `s_valid` high in cycles 1..8, error completion in cycle 9; a later `s_ready` from that slave produces no `m_ready`.
- Write with `m_wstrb`=4'b0011 to slave 0, followed back-to-back by a read to slave 1 → strobes and data reach slave 0 unchanged; the second `s_valid` rises 2 cycles after the first `m_ready`; never more than one `s_valid` bit high at a time.
- `rst` asserted in cycle 2 of a FWD access → `s_valid`=0 next cycle, no `m_ready`, `err_cnt`=0; the next request completes normally.
- 300 consecutive unmapped requests → `err_cnt` saturates at 255 and holds.
